mem_arbiter2: RTL and testbench

Two-master arbiter for the PicoRV32 native memory interface (valid/ready, addr, wdata, wstrb, rdata). It lets the CPU core (m0) and a second requester (m1: firmware loader, DMA or bench driver) share one downstream memory slave such as the simulation SRAM model. Arbitration is round-robin at transaction granularity. The grant is held until the slave completes the transfer.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_wdog.sv | 31 +++
 rtl/mem_arbiter2.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter2.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state, grant encodings and constants
// for the two-master PicoRV32 memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    localparam logic [31:0] WDOG_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arb_wdog.sv
// mem_arb_wdog: per-transfer cycle counter and expiry compare.
// Ports: clock, resetn (sync, active-low), busy (a grant is held),
// expired (counter has reached TIMEOUT).
module mem_arb_wdog
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clock,
    input  logic resetn,
    input  logic busy,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    assign expired = (cnt == CW'(TIMEOUT));

    // Cleared in every IDLE cycle, so each grant starts from zero.
    // Saturates at TIMEOUT so it can never wrap back below it.
    always_ff @(posedge clock) begin
        if (!resetn || !busy) begin
            cnt <= '0;
        end else if (!expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter2.sv
// mem_arbiter2: round-robin two-master arbiter for the PicoRV32
// native memory interface (valid/ready, addr, wdata, wstrb, rdata).
// Ports: clock, resetn (sync, active-low); m0_*/m1_* master sides
// (valid, addr, wdata, wstrb in; ready, rdata out); s_* slave side
// (valid, addr, wdata, wstrb out; ready, rdata in); grant (one-hot
// owner, 00 idle); err (watchdog abort pulse).
// Build option: MEM_ARB_WDOG_EN adds a TIMEOUT-cycle watchdog that
// aborts a stalled transfer; without it err is tied low.
module mem_arbiter2
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            m0_valid,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_wstrb,
    output logic            m0_ready,
    output logic [DW-1:0]   m0_rdata,
    input  logic            m1_valid,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_wstrb,
    output logic            m1_ready,
    output logic [DW-1:0]   m1_rdata,
    output logic            s_valid,
    output logic [AW-1:0]   s_addr,
    output logic [DW-1:0]   s_wdata,
    output logic [DW/8-1:0] s_wstrb,
    input  logic            s_ready,
    input  logic [DW-1:0]   s_rdata,
    output logic [1:0]      grant,
    output logic            err
);

    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("mem_arbiter2: TIMEOUT must be non-zero");
    end

    arb_state_t state;
    arb_state_t state_nx;
    logic       last;
    logic       busy;
    logic       wdog_hit;
    logic       done0;
    logic       done1;

    assign busy = (state != IDLE);

`ifdef MEM_ARB_WDOG_EN
    logic expired;

    mem_arb_wdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wdog (
        .clock  (clock),
        .resetn (resetn),
        .busy   (busy),
        .expired(expired)
    );

    // A real completion in the expiry cycle wins over the abort.
    assign wdog_hit = expired & ~s_ready;
`else
    assign wdog_hit = 1'b0;
`endif

    // A transfer finishes by slave completion or watchdog abort.
    // A master dropping valid early ends it with no ready pulse.
    assign done0 = (state == G0) & m0_valid & (s_ready | wdog_hit);
    assign done1 = (state == G1) & m1_valid & (s_ready | wdog_hit);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // last = 1 after reset so m0 wins the first tie.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            last <= 1'b1;
        end else if (done0) begin
            last <= 1'b0;
        end else if (done1) begin
            last <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (m0_valid && m1_valid) begin
                    state_nx = last ? G0 : G1;
                end else if (m0_valid) begin
                    state_nx = G0;
                end else if (m1_valid) begin
                    state_nx = G1;
                end
            end
            G0: begin
                if (!m0_valid || done0) begin
                    state_nx = IDLE;
                end
            end
            G1: begin
                if (!m1_valid || done1) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        s_valid  = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_wstrb  = '0;
        m0_ready = 1'b0;
        m0_rdata = '0;
        m1_ready = 1'b0;
        m1_rdata = '0;
        grant    = GRANT_NONE;
        err      = 1'b0;
        unique case (state)
            G0: begin
                grant    = GRANT_M0;
                s_valid  = m0_valid & ~wdog_hit;
                s_addr   = m0_addr;
                s_wdata  = m0_wdata;
                s_wstrb  = m0_wstrb;
                m0_ready = done0;
                m0_rdata = wdog_hit ? DW'(WDOG_RDATA) : s_rdata;
                err      = m0_valid & wdog_hit;
            end
            G1: begin
                grant    = GRANT_M1;
                s_valid  = m1_valid & ~wdog_hit;
                s_addr   = m1_addr;
                s_wdata  = m1_wdata;
                s_wstrb  = m1_wstrb;
                m1_ready = done1;
                m1_rdata = wdog_hit ? DW'(WDOG_RDATA) : s_rdata;
                err      = m1_valid & wdog_hit;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter2.sv
// tb_mem_arbiter2: scoreboard bench for mem_arbiter2 with a
// memory-backed slave model and randomized master traffic.
module tb_mem_arbiter2;

`ifdef MEM_ARB_WDOG_EN
    localparam int unsigned TO = 8;
`else
    localparam int unsigned TO = 255;
`endif

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        m0_valid = 1'b0;
    logic [31:0] m0_addr = '0;
    logic [31:0] m0_wdata = '0;
    logic [3:0]  m0_wstrb = '0;
    logic        m0_ready;
    logic [31:0] m0_rdata;
    logic        m1_valid = 1'b0;
    logic [31:0] m1_addr = '0;
    logic [31:0] m1_wdata = '0;
    logic [3:0]  m1_wstrb = '0;
    logic        m1_ready;
    logic [31:0] m1_rdata;
    logic        s_valid;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready = 1'b0;
    logic [31:0] s_rdata = '0;
    logic [1:0]  grant;
    logic        err;

    mem_arbiter2 #(
        .AW(32), .DW(32), .TIMEOUT(TO)
    ) dut (
        .clock(clock), .resetn(resetn),
        .m0_valid(m0_valid), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .err(err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
    } txn_t;

    txn_t        sb0[$];
    txn_t        sb1[$];
    txn_t        tmp_t;
    logic [31:0] model_mem[logic [31:0]];
    logic [31:0] slave_mem[logic [31:0]];

    int checks = 0;
    int failures = 0;
    int slave_mode = 0;
    int fixed_wait = 0;

    logic [1:0] prev_gnt = 2'b00;
    bit prev_v0 = 0;
    bit prev_v1 = 0;
    bit prev_rdy = 0;
    bit prev_rstn = 0;
    bit last_served = 1;

    function automatic logic [31:0] hashf(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : hashf(a);
    endfunction

    function automatic logic [31:0] slave_rd(input logic [31:0] a);
        return slave_mem.exists(a) ? slave_mem[a] : hashf(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int n, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        txn_t t;
        t.addr  = a;
        t.wdata = d;
        t.wstrb = s;
        t.rdata = model_rd(a);
        if (s != 4'h0) model_mem[a] = merge(model_rd(a), d, s);
        if (n == 0) begin
            sb0.push_back(t);
            m0_addr = a; m0_wdata = d; m0_wstrb = s; m0_valid = 1'b1;
        end else begin
            sb1.push_back(t);
            m1_addr = a; m1_wdata = d; m1_wstrb = s; m1_valid = 1'b1;
        end
    endtask

    task automatic wait_done(input int n, input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clock);
            seen = (n == 0) ? m0_ready : m1_ready;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_m%0d: ready=0 after %0d cycles, expected 1",
                     n, budget);
        end
        @(posedge clock);
        #1;
        if (n == 0) m0_valid = 1'b0;
        else m1_valid = 1'b0;
    endtask

    task automatic run_master(input int n, input int count);
        int          gap;
        logic [31:0] a;
        logic [3:0]  s;
        for (int k = 0; k < count; k++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clock);
                #1;
            end
            a = ((n == 0) ? 32'h1000 : 32'h2000) + 32'($urandom_range(0, 7)) * 4;
            s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            drive(n, a, $urandom, s);
            wait_done(n, 100);
        end
    endtask

    task automatic slave();
        int wl;
        bit busy;
        wl = 0;
        busy = 0;
        forever begin
            @(posedge clock);
            #2;
            if (s_valid && slave_mode != 2) begin
                if (!busy) begin
                    busy = 1;
                    wl = (slave_mode == 1) ? fixed_wait : $urandom_range(0, 3);
                end
                if (wl == 0) begin
                    s_ready = 1'b1;
                    if (s_wstrb == 4'h0) begin
                        s_rdata = slave_rd(s_addr);
                    end else begin
                        s_rdata = $urandom;
                        slave_mem[s_addr] = merge(slave_rd(s_addr), s_wdata, s_wstrb);
                    end
                    busy = 0;
                end else begin
                    wl--;
                    s_ready = 1'b0;
                    s_rdata = $urandom;
                end
            end else begin
                busy = 0;
                s_ready = (slave_mode == 0 && !s_valid) &&
                          ($urandom_range(0, 3) == 0);
                s_rdata = $urandom;
            end
        end
    endtask

    task automatic monitor();
        logic [1:0] exp_g;
        txn_t       t;
        forever begin
            @(negedge clock);
            if (resetn && prev_rstn) begin
                if (prev_rdy) exp_g = 2'b00;
                else if (prev_gnt == 2'b00) begin
                    if (prev_v0 && prev_v1) exp_g = last_served ? 2'b01 : 2'b10;
                    else if (prev_v0) exp_g = 2'b01;
                    else if (prev_v1) exp_g = 2'b10;
                    else exp_g = 2'b00;
                end else if (prev_gnt == 2'b01) exp_g = prev_v0 ? 2'b01 : 2'b00;
                else exp_g = prev_v1 ? 2'b10 : 2'b00;
                chk("arb_grant", 32'(grant), 32'(exp_g));
            end
            if (s_valid && s_ready) begin
                if (grant == 2'b01 && sb0.size() > 0) begin
                    chk("s_addr_m0", s_addr, sb0[0].addr);
                    chk("s_wstrb_m0", 32'(s_wstrb), 32'(sb0[0].wstrb));
                    if (sb0[0].wstrb != 4'h0) chk("s_wdata_m0", s_wdata, sb0[0].wdata);
                end else if (grant == 2'b10 && sb1.size() > 0) begin
                    chk("s_addr_m1", s_addr, sb1[0].addr);
                    chk("s_wstrb_m1", 32'(s_wstrb), 32'(sb1[0].wstrb));
                    if (sb1[0].wstrb != 4'h0) chk("s_wdata_m1", s_wdata, sb1[0].wdata);
                end else begin
                    checks++;
                    failures++;
                    $display("FAIL s_owner: grant=%b with no pending request", grant);
                end
            end
            if (m0_ready) begin
                chk("m0_owner", 32'(grant), 32'd1);
                if (sb0.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL m0_spurious: ready=1 with 0 pending, expected 0");
                end else begin
                    t = sb0.pop_front();
                    if (t.wstrb == 4'h0) chk("m0_rdata", m0_rdata, t.rdata);
                end
            end
            if (m1_ready) begin
                chk("m1_owner", 32'(grant), 32'd2);
                if (sb1.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL m1_spurious: ready=1 with 0 pending, expected 0");
                end else begin
                    t = sb1.pop_front();
                    if (t.wstrb == 4'h0) chk("m1_rdata", m1_rdata, t.rdata);
                end
            end
            if (!resetn) last_served = 1;
            else if (m0_ready) last_served = 0;
            else if (m1_ready) last_served = 1;
            prev_gnt  = grant;
            prev_v0   = m0_valid;
            prev_v1   = m1_valid;
            prev_rdy  = m0_ready | m1_ready;
            prev_rstn = resetn;
        end
    endtask

    initial begin
        fork
            monitor();
            slave();
        join_none

        resetn = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_s_valid", 32'(s_valid), 32'd0);
        chk("rst_s_addr", s_addr, 32'd0);
        chk("rst_s_wdata", s_wdata, 32'd0);
        chk("rst_s_wstrb", 32'(s_wstrb), 32'd0);
        chk("rst_m0_ready", 32'(m0_ready), 32'd0);
        chk("rst_m1_ready", 32'(m1_ready), 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clock);
        #1 resetn = 1'b1;

        // Single zero-wait read by m0.
        slave_mode = 1;
        fixed_wait = 0;
        model_mem[32'h100] = 32'h12345678;
        slave_mem[32'h100] = 32'h12345678;
        @(posedge clock);
        #1 drive(0, 32'h100, 32'h0, 4'h0);
        @(negedge clock);
        chk("rd_idle_grant", 32'(grant), 32'd0);
        @(negedge clock);
        chk("rd_grant", 32'(grant), 32'd1);
        chk("rd_m0_ready", 32'(m0_ready), 32'd1);
        chk("rd_m0_rdata", m0_rdata, 32'h12345678);
        chk("rd_m1_ready", 32'(m1_ready), 32'd0);
        @(posedge clock);
        #1 m0_valid = 1'b0;
        @(negedge clock);
        chk("rd_after_grant", 32'(grant), 32'd0);
        chk("rd_after_m0_ready", 32'(m0_ready), 32'd0);
        chk("rd_after_m1_ready", 32'(m1_ready), 32'd0);

        // m1 write with three slave wait states.
        fixed_wait = 3;
        @(posedge clock);
        #1;
        fork
            begin
                drive(1, 32'h2040, 32'hA5A5A5A5, 4'hF);
                wait_done(1, 20);
            end
            begin
                automatic int pulses;
                pulses = 0;
                for (int i = 0; i < 6; i++) begin
                    @(negedge clock);
                    if (m1_ready) pulses++;
                    if (i >= 1 && i <= 4) begin
                        chk("wr_s_valid", 32'(s_valid), 32'd1);
                        chk("wr_s_wdata", s_wdata, 32'hA5A5A5A5);
                        chk("wr_s_wstrb", 32'(s_wstrb), 32'hF);
                    end
                end
                chk("wr_pulses", 32'(pulses), 32'd1);
            end
        join

        // Contention from reset release: strict alternation.
        fixed_wait = 0;
        @(posedge clock);
        #1 resetn = 1'b0;
        drive(0, 32'h1000, 32'h0, 4'h0);
        drive(1, 32'h2000, 32'h0, 4'h0);
        @(posedge clock);
        #1 resetn = 1'b1;
        fork
            begin
                wait_done(0, 20);
                drive(0, 32'h1000, 32'h0, 4'h0);
                wait_done(0, 20);
            end
            begin
                wait_done(1, 20);
                drive(1, 32'h2000, 32'h0, 4'h0);
                wait_done(1, 20);
            end
            begin
                automatic logic [1:0] eg;
                for (int i = 0; i < 8; i++) begin
                    @(negedge clock);
                    eg = (i % 2 == 0) ? 2'b00 : ((i % 4 == 1) ? 2'b01 : 2'b10);
                    chk("cont_grant", 32'(grant), 32'(eg));
                    if (eg == 2'b01) chk("cont_s_addr", s_addr, 32'h1000);
                    if (eg == 2'b10) chk("cont_s_addr", s_addr, 32'h2000);
                end
            end
        join

        // Reset while m0 owns a stalled transfer.
        slave_mode = 2;
        @(posedge clock);
        #1 drive(0, 32'h1008, 32'h0, 4'h0);
        @(negedge clock);
        @(negedge clock);
        chk("mid_grant", 32'(grant), 32'd1);
        chk("mid_s_valid", 32'(s_valid), 32'd1);
        @(posedge clock);
        #1 resetn = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_s_valid", 32'(s_valid), 32'd0);
        m0_valid = 1'b0;
        void'(sb0.pop_front());
        slave_mode = 1;
        fixed_wait = 0;
        @(posedge clock);
        #1;
        drive(0, 32'h1008, 32'h0, 4'h0);
        drive(1, 32'h2008, 32'h0, 4'h0);
        @(posedge clock);
        #1 resetn = 1'b1;
        fork
            wait_done(0, 20);
            wait_done(1, 20);
            begin
                @(negedge clock);
                chk("tie_idle_grant", 32'(grant), 32'd0);
                @(negedge clock);
                chk("tie_grant", 32'(grant), 32'd1);
            end
        join

        // Slave never responds.
        slave_mode = 2;
        @(posedge clock);
        #1 drive(0, 32'h1010, 32'h0, 4'h0);
`ifdef MEM_ARB_WDOG_EN
        tmp_t = sb0.pop_back();
        tmp_t.rdata = 32'hDEADBEEF;
        sb0.push_back(tmp_t);
        begin
            automatic int gcyc;
            automatic int rcyc;
            automatic logic er;
            automatic logic [31:0] rd;
            gcyc = -1;
            rcyc = -1;
            er = 1'b0;
            rd = '0;
            for (int i = 0; i < 40 && rcyc < 0; i++) begin
                @(negedge clock);
                if (grant == 2'b01 && gcyc < 0) gcyc = i;
                if (m0_ready) begin
                    rcyc = i;
                    er = err;
                    rd = m0_rdata;
                end
            end
            chk("wdog_latency", 32'(rcyc - gcyc), 32'd8);
            chk("wdog_err", 32'(er), 32'd1);
            chk("wdog_rdata", rd, 32'hDEADBEEF);
        end
        @(posedge clock);
        #1 m0_valid = 1'b0;
        @(negedge clock);
        chk("wdog_err_pulse", 32'(err), 32'd0);
        chk("wdog_idle_grant", 32'(grant), 32'd0);
`else
        begin
            automatic int rdy_n;
            automatic int err_n;
            rdy_n = 0;
            err_n = 0;
            repeat (100) begin
                @(negedge clock);
                if (m0_ready) rdy_n++;
                if (err) err_n++;
            end
            chk("pend_grant", 32'(grant), 32'd1);
            chk("pend_s_valid", 32'(s_valid), 32'd1);
            chk("pend_ready", 32'(rdy_n), 32'd0);
            chk("pend_err", 32'(err_n), 32'd0);
        end
        @(posedge clock);
        #1 resetn = 1'b0;
        m0_valid = 1'b0;
        void'(sb0.pop_front());
        @(posedge clock);
        #1 resetn = 1'b1;
`endif

        // Random traffic from both masters.
        slave_mode = 0;
        @(posedge clock);
        #1;
        fork
            run_master(0, 40);
            run_master(1, 40);
        join
        @(negedge clock);
        chk("sb0_empty", 32'(sb0.size()), 32'd0);
        chk("sb1_empty", 32'(sb1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
